// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: owns the single register-file write port and shares it
// between the in-order pipeline and a 2-entry FIFO of multi-cycle results.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_write,
   input  logic [3:0]  pipe_reg,
   input  logic [1:0]  pipe_quarter,
   input  logic [15:0] pipe_data,
   input  logic        aux_valid,
   output logic        aux_ready,
   input  logic [3:0]  aux_reg,
   input  logic [1:0]  aux_quarter,
   input  logic [15:0] aux_data,
   output logic        rf_we,
   output logic [3:0]  rf_reg,
   output logic [1:0]  rf_quarter,
   output logic [15:0] rf_data,
   output logic [15:0] busy,
   output logic        stall_req,
   output logic        err
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef struct packed {
      logic [3:0]  rd;
      logic [1:0]  qtr;
      logic [15:0] data;
   } aux_ent_t;

   aux_ent_t   slot0_q;
   aux_ent_t   slot1_q;
   aux_ent_t   slot0_d;
   aux_ent_t   slot1_d;
   aux_ent_t   push_ent;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic [3:0] starve_q;
   logic       live_q;
   logic       accept;
   logic       pop;
   logic       hit0;
   logic       hit1;
   logic       keep0;
   logic       keep1;

   // Handshake and stall request come from registered state only
   always_comb begin
      aux_ready = live_q && (count_q < 2'd2);
      stall_req = (starve_q >= LIMIT) && (count_q != 2'd0);
      accept    = aux_valid && aux_ready;
      pop       = !pipe_write && (count_q != 2'd0);
   end

   // A pipeline write to the same reg/quarter supersedes buffered entries
   always_comb begin
      hit0 = pipe_write && (count_q >= 2'd1) &&
             (slot0_q.rd == pipe_reg) &&
             (slot0_q.qtr == pipe_quarter);
      hit1 = pipe_write && (count_q == 2'd2) &&
             (slot1_q.rd == pipe_reg) &&
             (slot1_q.qtr == pipe_quarter);
      keep0 = (count_q >= 2'd1) && !hit0 && !pop;
      keep1 = (count_q == 2'd2) && !hit1;
   end

   // Compact surviving entries toward the head, then append any push
   always_comb begin
      slot0_d  = slot0_q;
      slot1_d  = slot1_q;
      count_d  = 2'd0;
      push_ent = '{rd: aux_reg, qtr: aux_quarter, data: aux_data};
      if (keep0) begin
         count_d = 2'd1;
      end
      if (keep1) begin
         if (!keep0) begin
            slot0_d = slot1_q;
         end
         count_d = count_d + 2'd1;
      end
      if (accept) begin
         if (count_d == 2'd0) begin
            slot0_d = push_ent;
         end else begin
            slot1_d = push_ent;
         end
         count_d = count_d + 2'd1;
      end
   end

   // FIFO storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   // aux_ready stays low until the first edge out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
      end
   end

   // Count edges the buffered head lost the port to the pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= 4'd0;
      end else if (pipe_write && (count_q != 2'd0)) begin
         if (starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
         end
      end else begin
         starve_q <= 4'd0;
      end
   end

   // Registered write port: pipeline first, else FIFO head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_reg     <= 4'd0;
         rf_quarter <= 2'd0;
         rf_data    <= 16'd0;
      end else if (pipe_write) begin
         rf_we      <= 1'b1;
         rf_reg     <= pipe_reg;
         rf_quarter <= pipe_quarter;
         rf_data    <= pipe_data;
      end else if (count_q != 2'd0) begin
         rf_we      <= 1'b1;
         rf_reg     <= slot0_q.rd;
         rf_quarter <= slot0_q.qtr;
         rf_data    <= slot0_q.data;
      end else begin
         rf_we      <= 1'b0;
      end
   end

   // Sticky flag: superseded entries or pipeline ignoring a stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (pipe_write && (hit0 || hit1 || stall_req)) begin
         err <= 1'b1;
      end
   end

   // Scoreboard view of registers still owed a buffered aux write
   always_comb begin
      busy = 16'd0;
      if (count_q >= 2'd1) begin
         busy[slot0_q.rd] = 1'b1;
      end
      if (count_q == 2'd2) begin
         busy[slot1_q.rd] = 1'b1;
      end
   end

endmodule
